mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 21 ++
 rtl/wait_counter.sv | 34 +++
 rtl/mem_arbiter.sv | 134 +++++++++++++
 tb/tb_mem_arbiter.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter_pkg
// Purpose  : Shared types and constants for the fetch/data memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic C_GRANT_IF            = 1'b0;
    localparam logic C_GRANT_D             = 1'b1;
    localparam int   C_DEFAULT_WAIT_CYCLES = 4;
    localparam int   C_CNT_WIDTH           = 4;

endpackage
`default_nettype wire

// File: rtl/wait_counter.sv
`default_nettype none
// ============================================================================
// Module   : wait_counter
// Purpose  : Access-length counter; tc is high on the last counted cycle.
// Revision : 1.0 - initial release
// ============================================================================
module wait_counter
    import mem_arbiter_pkg::*;
#(
    parameter logic [C_CNT_WIDTH-1:0] LIMIT = C_CNT_WIDTH'(C_DEFAULT_WAIT_CYCLES)
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    logic [C_CNT_WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (clear || (enable && tc)) begin
            r_count <= '0;
        end else if (enable) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign tc = (r_count == LIMIT - 1'b1);

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Arbitrates fetch and data ports onto one fixed-latency memory.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int WAIT_CYCLES = C_DEFAULT_WAIT_CYCLES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ready,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        if_stall,
    output logic        d_stall
);

    state_t      r_state;
    state_t      w_next_state;
    logic        r_grant;
    logic        w_next_grant;
    logic        r_last_grant;
    logic [31:0] r_if_rdata;
    logic [31:0] r_d_rdata;
    logic        w_in_access;
    logic        w_tc;

    assign w_in_access = (r_state == ACCESS);

    wait_counter #(
        .LIMIT (C_CNT_WIDTH'(WAIT_CYCLES))
    ) u_wait_counter (
        .clk    (clk),
        .rst    (rst),
        .clear  (~w_in_access),
        .enable (w_in_access),
        .tc     (w_tc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_grant      <= C_GRANT_IF;
            r_last_grant <= C_GRANT_IF;
        end else begin
            r_state <= w_next_state;
            r_grant <= w_next_grant;
            if (r_state == DONE) begin
                r_last_grant <= r_grant;
            end
        end
    end

    // Read data is captured on the final access cycle; writes leave d_rdata alone.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_if_rdata <= '0;
            r_d_rdata  <= '0;
        end else if (w_in_access && w_tc) begin
            if (r_grant == C_GRANT_D) begin
                if (!d_we) begin
                    r_d_rdata <= mem_rdata;
                end
            end else begin
                r_if_rdata <= mem_rdata;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_grant = r_grant;
        mem_en       = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        case (r_state)
            IDLE: begin
                if (if_req || d_req) begin
                    w_next_state = ACCESS;
                    if (if_req && d_req) begin
                        // Data normally wins a tie, but never twice in a row.
                        w_next_grant = (r_last_grant == C_GRANT_D) ? C_GRANT_IF : C_GRANT_D;
                    end else begin
                        w_next_grant = d_req ? C_GRANT_D : C_GRANT_IF;
                    end
                end
            end
            ACCESS: begin
                mem_en = 1'b1;
                if (r_grant == C_GRANT_D) begin
                    mem_we    = d_we;
                    mem_addr  = d_addr;
                    mem_wdata = d_wdata;
                end else begin
                    mem_addr  = if_addr;
                end
                if (w_tc) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    assign if_ready = (r_state == DONE) && (r_grant == C_GRANT_IF);
    assign d_ready  = (r_state == DONE) && (r_grant == C_GRANT_D);
    assign if_rdata = r_if_rdata;
    assign d_rdata  = r_d_rdata;
    assign if_stall = if_req & ~if_ready;
    assign d_stall  = d_req & ~d_ready;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Self-checking bench for mem_arbiter (WAIT_CYCLES = 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int W = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        if_stall;
    logic        d_stall;

    logic        use_fixed;
    logic [31:0] fixed_rdata;
    int          checks = 0;
    int          errors = 0;

    mem_arbiter #(.WAIT_CYCLES(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ready  (if_ready),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_ready   (d_ready),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .if_stall  (if_stall),
        .d_stall   (d_stall)
    );

    always #5 clk = ~clk;

    // Memory content is a fixed scramble of the address.
    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    always_comb mem_rdata = use_fixed ? fixed_rdata : mem_fn(mem_addr);

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({if_ready, d_ready, mem_en, mem_we, if_stall, d_stall} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b, want 000000", {if_ready, d_ready, mem_en, mem_we, if_stall, d_stall});
        end
        checks++;
        if ({mem_addr, mem_wdata, if_rdata, d_rdata} !== 128'b0) begin
            errors++;
            $display("FAIL reset_data: got %h %h %h %h, want all zero", mem_addr, mem_wdata, if_rdata, d_rdata);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({if_ready, d_ready, mem_en} !== 3'b0) begin
            errors++;
            $display("FAIL reset_release_idle: got %b, want 000", {if_ready, d_ready, mem_en});
        end
    endtask

    task automatic test_if_read();
        use_fixed   = 1'b1;
        fixed_rdata = 32'hE3A0_0001;
        for (int c = 0; c <= 5; c++) begin
            @(posedge clk); #1;
            if (c == 0) begin
                if_req  = 1'b1;
                if_addr = 32'h10;
            end
            @(negedge clk);
            checks++;
            if ({mem_en, mem_we, if_ready, if_stall, d_stall} !==
                {(c >= 1 && c <= 4), 1'b0, (c == 5), (c <= 4), 1'b0}) begin
                errors++;
                $display("FAIL if_read_ctrl c=%0d: got en/we/rdy/ist/dst=%b, want %b", c,
                         {mem_en, mem_we, if_ready, if_stall, d_stall},
                         {(c >= 1 && c <= 4), 1'b0, (c == 5), (c <= 4), 1'b0});
            end
            checks++;
            if (mem_addr !== ((c >= 1 && c <= 4) ? 32'h10 : 32'h0)) begin
                errors++;
                $display("FAIL if_read_addr c=%0d: got %h", c, mem_addr);
            end
        end
        checks++;
        if (if_rdata !== 32'hE3A0_0001) begin
            errors++;
            $display("FAIL if_read_data: got %h, want e3a00001", if_rdata);
        end
        @(posedge clk); #1;
        if_req  = 1'b0;
        if_addr = '0;
        @(negedge clk);
        checks++;
        if ({if_ready, if_rdata} !== {1'b0, 32'hE3A0_0001}) begin
            errors++;
            $display("FAIL if_read_hold: got rdy=%b data=%h, want 0 e3a00001", if_ready, if_rdata);
        end
        use_fixed = 1'b0;
    endtask

    task automatic test_simultaneous();
        logic [31:0] exp_addr;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        for (int c = 0; c <= 11; c++) begin
            if (c == 0) begin
                rst     = 1'b1;
                if_req  = 1'b1;
                if_addr = 32'h3C;
                d_req   = 1'b1;
                d_we    = 1'b0;
                d_addr  = 32'h200;
            end else begin
                @(posedge clk); #1;
                if (c == 6) d_req = 1'b0;
            end
            @(negedge clk);
            exp_addr = (c >= 1 && c <= 4) ? 32'h200 : ((c >= 7 && c <= 10) ? 32'h3C : 32'h0);
            checks++;
            if ({d_ready, if_ready, if_stall, mem_en} !==
                {(c == 5), (c == 11), (c <= 10), (exp_addr != 0)}) begin
                errors++;
                $display("FAIL simul_ctrl c=%0d: got drdy/irdy/ist/en=%b", c, {d_ready, if_ready, if_stall, mem_en});
            end
            checks++;
            if (mem_addr !== exp_addr) begin
                errors++;
                $display("FAIL simul_addr c=%0d: got %h, want %h", c, mem_addr, exp_addr);
            end
        end
        checks++;
        if ({d_rdata, if_rdata} !== {mem_fn(32'h200), mem_fn(32'h3C)}) begin
            errors++;
            $display("FAIL simul_data: got d=%h i=%h, want d=%h i=%h", d_rdata, if_rdata, mem_fn(32'h200), mem_fn(32'h3C));
        end
        @(posedge clk); #1;
        if_req = 1'b0;
    endtask

    task automatic test_data_write();
        logic act;
        for (int c = 0; c <= 5; c++) begin
            @(posedge clk); #1;
            if (c == 0) begin
                d_req   = 1'b1;
                d_we    = 1'b1;
                d_addr  = 32'h104;
                d_wdata = 32'hDEAD_BEEF;
            end
            @(negedge clk);
            act = (c >= 1 && c <= 4);
            checks++;
            if ({mem_en, mem_we, d_ready, d_stall} !== {act, act, (c == 5), (c <= 4)}) begin
                errors++;
                $display("FAIL write_ctrl c=%0d: got en/we/rdy/dst=%b", c, {mem_en, mem_we, d_ready, d_stall});
            end
            checks++;
            if ({mem_addr, mem_wdata} !== (act ? {32'h104, 32'hDEAD_BEEF} : 64'h0)) begin
                errors++;
                $display("FAIL write_bus c=%0d: got addr=%h wdata=%h", c, mem_addr, mem_wdata);
            end
            checks++;
            if (d_rdata !== mem_fn(32'h200)) begin
                errors++;
                $display("FAIL write_rdata_kept c=%0d: got %h, want %h", c, d_rdata, mem_fn(32'h200));
            end
        end
        @(posedge clk); #1;
        d_req = 1'b0;
        d_we  = 1'b0;
    endtask

    task automatic test_fairness();
        int   ev_cyc[$];
        logic ev_d[$];
        int   exp_cyc[4] = '{5, 11, 17, 23};
        logic exp_d[4]   = '{1'b1, 1'b0, 1'b1, 1'b0};
        int   first_clr  = -1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        for (int c = 0; c <= 23; c++) begin
            if (c == 0) begin
                rst     = 1'b1;
                if_req  = 1'b1;
                if_addr = 32'h80;
                d_req   = 1'b1;
                d_we    = 1'b0;
                d_addr  = 32'h300;
            end else begin
                @(posedge clk); #1;
            end
            @(negedge clk);
            if (d_ready)  begin ev_cyc.push_back(c); ev_d.push_back(1'b1); end
            if (if_ready) begin ev_cyc.push_back(c); ev_d.push_back(1'b0); end
            if (first_clr < 0 && !if_stall) first_clr = c;
        end
        checks++;
        if (ev_cyc.size() != 4) begin
            errors++;
            $display("FAIL fair_count: got %0d ready pulses, want 4", ev_cyc.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (ev_cyc[i] != exp_cyc[i] || ev_d[i] !== exp_d[i]) begin
                    errors++;
                    $display("FAIL fair_grant%0d: got cycle %0d data=%b, want cycle %0d data=%b",
                             i, ev_cyc[i], ev_d[i], exp_cyc[i], exp_d[i]);
                end
            end
        end
        checks++;
        if (first_clr != 11) begin
            errors++;
            $display("FAIL fair_if_stall_clear: got cycle %0d, want 11", first_clr);
        end
        @(posedge clk); #1;
        if_req = 1'b0;
        d_req  = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_access();
        for (int c = 0; c <= 1; c++) begin
            @(posedge clk); #1;
            if (c == 0) begin
                if_req  = 1'b1;
                if_addr = 32'h44;
            end
            @(negedge clk);
        end
        checks++;
        if (mem_en !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_pre: got mem_en=%b, want 1", mem_en);
        end
        @(posedge clk); #1;
        rst    = 1'b0;
        if_req = 1'b0;
        #1;
        checks++;
        if ({mem_en, mem_we, mem_addr, if_ready, if_rdata, d_rdata} !== 99'b0) begin
            errors++;
            $display("FAIL rstmid_immediate: got en=%b addr=%h rdy=%b ird=%h drd=%h",
                     mem_en, mem_addr, if_ready, if_rdata, d_rdata);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if ({if_ready, d_ready, mem_en} !== 3'b0) begin
                errors++;
                $display("FAIL rstmid_hold k=%0d: got %b, want 000", k, {if_ready, d_ready, mem_en});
            end
        end
        for (int c = 0; c <= 5; c++) begin
            @(posedge clk); #1;
            if (c == 0) begin
                rst     = 1'b1;
                if_req  = 1'b1;
                if_addr = 32'h48;
            end
            @(negedge clk);
            checks++;
            if ({if_ready, mem_en} !== {(c == 5), (c >= 1 && c <= 4)}) begin
                errors++;
                $display("FAIL rstmid_after c=%0d: got rdy/en=%b", c, {if_ready, mem_en});
            end
        end
        checks++;
        if (if_rdata !== mem_fn(32'h48)) begin
            errors++;
            $display("FAIL rstmid_data: got %h, want %h", if_rdata, mem_fn(32'h48));
        end
        @(posedge clk); #1;
        if_req = 1'b0;
    endtask

    // Transaction-level model: each grant occupies the memory for W cycles
    // followed by one ready cycle; ties go to data unless data was served last.
    task automatic test_random(input int ncyc);
        logic        ipend = 1'b0, dpend = 1'b0, last_d = 1'b0, have = 1'b0;
        logic        srv_d = 1'b0, s_we = 1'b0, e_ir = 1'b0, e_dr = 1'b0;
        logic        in_acc, done;
        logic [31:0] s_addr = '0, s_wdata = '0, exp_ird = '0, exp_drd = '0;
        logic [31:0] e_addr, e_wd;
        int          s = 0, free_at = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        for (int c = 0; c < ncyc; c++) begin
            if (c == 0) rst = 1'b1;
            else begin @(posedge clk); #1; end
            if (e_ir) begin ipend = 1'b0; if_req = 1'b0; end
            if (e_dr) begin dpend = 1'b0; d_req = 1'b0; end
            if (!ipend && $urandom_range(2) == 0) begin
                ipend = 1'b1; if_req = 1'b1; if_addr = $urandom;
            end
            if (!dpend && $urandom_range(2) == 0) begin
                dpend = 1'b1; d_req = 1'b1; d_addr = $urandom;
                d_we = 1'($urandom_range(1)); d_wdata = $urandom;
            end
            if (c >= free_at && (if_req || d_req)) begin
                srv_d   = d_req && (!if_req || !last_d);
                last_d  = srv_d;
                have    = 1'b1;
                s       = c;
                free_at = c + W + 2;
                s_addr  = srv_d ? d_addr : if_addr;
                s_we    = srv_d ? d_we : 1'b0;
                s_wdata = srv_d ? d_wdata : 32'h0;
            end
            in_acc = have && c > s && c <= s + W;
            done   = have && c == s + W + 1;
            e_ir   = done && !srv_d;
            e_dr   = done && srv_d;
            if (e_ir) exp_ird = mem_fn(s_addr);
            if (e_dr && !s_we) exp_drd = mem_fn(s_addr);
            // Occasionally withdraw the granted request mid-access.
            if (in_acc && $urandom_range(7) == 0) begin
                if (srv_d) d_req = 1'b0;
                else       if_req = 1'b0;
            end
            e_addr = in_acc ? s_addr : 32'h0;
            e_wd   = in_acc ? s_wdata : 32'h0;
            @(negedge clk);
            checks++;
            if ({if_ready, d_ready, mem_en, mem_we, if_stall, d_stall} !==
                {e_ir, e_dr, in_acc, in_acc && s_we, if_req && !e_ir, d_req && !e_dr}) begin
                errors++;
                $display("FAIL rand_ctrl c=%0d: got %b, want %b", c,
                         {if_ready, d_ready, mem_en, mem_we, if_stall, d_stall},
                         {e_ir, e_dr, in_acc, in_acc && s_we, if_req && !e_ir, d_req && !e_dr});
            end
            checks++;
            if (mem_addr !== e_addr) begin
                errors++;
                $display("FAIL rand_addr c=%0d: got %h, want %h", c, mem_addr, e_addr);
            end
            if (!in_acc || srv_d) begin
                checks++;
                if (mem_wdata !== e_wd) begin
                    errors++;
                    $display("FAIL rand_wdata c=%0d: got %h, want %h", c, mem_wdata, e_wd);
                end
            end
            checks++;
            if ({if_rdata, d_rdata} !== {exp_ird, exp_drd}) begin
                errors++;
                $display("FAIL rand_rdata c=%0d: got i=%h d=%h, want i=%h d=%h",
                         c, if_rdata, d_rdata, exp_ird, exp_drd);
            end
        end
        @(posedge clk); #1;
        if_req = 1'b0;
        d_req  = 1'b0;
        repeat (W + 2) @(posedge clk);
    endtask

    initial begin
        rst         = 1'b0;
        if_req      = 1'b0;
        if_addr     = '0;
        d_req       = 1'b0;
        d_we        = 1'b0;
        d_addr      = '0;
        d_wdata     = '0;
        use_fixed   = 1'b0;
        fixed_rdata = '0;
        test_reset();
        test_if_read();
        test_simultaneous();
        test_data_write();
        test_fairness();
        test_reset_mid_access();
        test_random(400);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
